// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: drives the shared comparator, resolves direction
// and target, checks against a 2-bit-counter BHT and counts mispredicts.
module branch_ctrl #(
    parameter int BHT_IDX = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_imm,
    input  logic [31:0]      br_rs1,
    input  logic [31:0]      br_rs2,
    input  logic             br_pred,
    input  logic [31:0]      f_pc,
    output logic             f_pred,
    output logic             cmp_un,
    output logic [31:0]      cmp_rr1,
    output logic [31:0]      cmp_rr2,
    input  logic             cmp_beq,
    input  logic             cmp_blt,
    output logic             res_valid,
    output logic             res_taken,
    output logic [31:0]      res_target,
    output logic             res_mispredict,
    output logic             res_illegal,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int BHT_N = 1 << BHT_IDX;

    typedef enum logic [1:0] {IDLE, CMP, RES} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 funct3_q, funct3_d;
    logic [31:0]                pc_q, pc_d;
    logic [31:0]                imm_q, imm_d;
    logic                       pred_q, pred_d;
    logic                       cmp_un_q, cmp_un_d;
    logic [31:0]                cmp_rr1_q, cmp_rr1_d;
    logic [31:0]                cmp_rr2_q, cmp_rr2_d;
    logic                       taken_q, taken_d;
    logic                       illegal_q, illegal_d;
    logic [31:0]                target_q, target_d;
    logic [BHT_N-1:0][1:0]      bht_q, bht_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BHT_IDX-1:0]         upd_idx, f_idx;
    logic                       accept;
    logic                       unused_f_pc;

    assign br_ready       = (state_q == IDLE) && !kill;
    assign accept         = br_valid && br_ready;
    assign upd_idx        = pc_q[BHT_IDX+1:2];
    assign f_idx          = f_pc[BHT_IDX+1:2];
    assign unused_f_pc    = ^{f_pc[31:BHT_IDX+2], f_pc[1:0]};
    // Reads the registered table, so a same-cycle RES update is not visible yet.
    assign f_pred         = bht_q[f_idx][1];

    assign cmp_un         = cmp_un_q;
    assign cmp_rr1        = cmp_rr1_q;
    assign cmp_rr2        = cmp_rr2_q;
    assign res_valid      = (state_q == RES) && !kill;
    assign res_taken      = taken_q;
    assign res_target     = target_q;
    assign res_mispredict = taken_q ^ pred_q;
    assign res_illegal    = illegal_q;
    assign mispred_cnt    = cnt_q;

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        pred_d    = pred_q;
        cmp_un_d  = cmp_un_q;
        cmp_rr1_d = cmp_rr1_q;
        cmp_rr2_d = cmp_rr2_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        target_d  = target_q;
        bht_d     = bht_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d  = br_funct3;
                    pc_d      = br_pc;
                    imm_d     = br_imm;
                    pred_d    = br_pred;
                    cmp_un_d  = br_funct3[1];
                    cmp_rr1_d = br_rs1;
                    cmp_rr2_d = br_rs2;
                    state_d   = CMP;
                end
            end
            CMP: begin
                illegal_d = 1'b0;
                unique case (funct3_q)
                    3'b000:         taken_d = cmp_beq;
                    3'b001:         taken_d = !cmp_beq;
                    3'b100, 3'b110: taken_d = cmp_blt;
                    3'b101, 3'b111: taken_d = !cmp_blt;
                    default: begin
                        taken_d   = 1'b0;
                        illegal_d = 1'b1;
                    end
                endcase
                target_d = pc_q + (taken_d ? imm_q : 32'd4);
                state_d  = kill ? IDLE : RES;
            end
            RES: begin
                state_d = IDLE;
                if (!kill && !illegal_q) begin
                    if (taken_q && bht_q[upd_idx] != 2'b11)
                        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
                    else if (!taken_q && bht_q[upd_idx] != 2'b00)
                        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
                    if ((taken_q ^ pred_q) && cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            pred_q    <= 1'b0;
            cmp_un_q  <= 1'b0;
            cmp_rr1_q <= '0;
            cmp_rr2_q <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
            bht_q     <= {BHT_N{2'b01}};
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            pred_q    <= pred_d;
            cmp_un_q  <= cmp_un_d;
            cmp_rr1_q <= cmp_rr1_d;
            cmp_rr2_q <= cmp_rr2_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            target_q  <= target_d;
            bht_q     <= bht_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed vector table, multi-cycle corner sequences and
// random branches against a behavioural model of the BHT and mispredict counter.
module tb_branch_ctrl;
    localparam int BHT_IDX = 4;
    localparam int CNT_W   = 3;   // small so saturation is reachable
    localparam int NENT    = 1 << BHT_IDX;

    logic clk = 0, rst = 0, kill = 0, br_valid = 0, br_pred = 0;
    logic br_ready, f_pred, cmp_un, cmp_beq, cmp_blt;
    logic res_valid, res_taken, res_mispredict, res_illegal;
    logic [2:0] br_funct3 = 0;
    logic [31:0] br_pc = 0, br_imm = 0, br_rs1 = 0, br_rs2 = 0, f_pc = 0;
    logic [31:0] cmp_rr1, cmp_rr2, res_target;
    logic [CNT_W-1:0] mispred_cnt;

    int n_chk = 0, n_fail = 0;
    int m_bht[NENT];
    int m_cnt;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared comparator.
    assign cmp_beq = (cmp_rr1 == cmp_rr2);
    assign cmp_blt = cmp_un ? (cmp_rr1 < cmp_rr2) : ($signed(cmp_rr1) < $signed(cmp_rr2));

    branch_ctrl #(.BHT_IDX(BHT_IDX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .kill(kill), .br_valid(br_valid), .br_ready(br_ready),
        .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1),
        .br_rs2(br_rs2), .br_pred(br_pred), .f_pc(f_pc), .f_pred(f_pred),
        .cmp_un(cmp_un), .cmp_rr1(cmp_rr1), .cmp_rr2(cmp_rr2), .cmp_beq(cmp_beq),
        .cmp_blt(cmp_blt), .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .res_mispredict(res_mispredict),
        .res_illegal(res_illegal), .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1, rs2;
        logic        pred;
        logic        taken;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_bht[i] = 1;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; kill = 0; br_valid = 0;
        @(negedge clk); rst = 0;
        model_reset();
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
        br_funct3 = f3; br_pc = pc; br_imm = imm; br_rs1 = rs1; br_rs2 = rs2; br_pred = pred;
        br_valid = 1;
    endtask

    // One full branch; leaves the bench at a negedge with the DUT back in IDLE.
    task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                             input logic e_taken, input logic [31:0] e_tgt, input logic e_ill);
        int idx;
        idx = int'(pc[BHT_IDX+1:2]);
        @(negedge clk);
        chk("br_ready_idle", br_ready, 1);
        drive(f3, pc, imm, rs1, rs2, pred);
        @(negedge clk);
        br_valid = 0;
        f_pc = pc;
        chk("cmp_un", cmp_un, f3[1]);
        chk("cmp_rr1", cmp_rr1, rs1);
        chk("cmp_rr2", cmp_rr2, rs2);
        chk("no_res_in_cmp", res_valid, 0);
        chk("busy_ready", br_ready, 0);
        @(negedge clk);
        chk("res_valid", res_valid, 1);
        chk("res_taken", res_taken, e_taken);
        chk("res_target", res_target, e_tgt);
        chk("res_illegal", res_illegal, e_ill);
        chk("res_mispredict", res_mispredict, e_taken ^ pred);
        chk("f_pred_old", f_pred, m_bht[idx] >> 1);
        if (!e_ill) begin
            if (e_taken && m_bht[idx] < 3) m_bht[idx]++;
            if (!e_taken && m_bht[idx] > 0) m_bht[idx]--;
            if ((e_taken != pred) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        @(negedge clk);
        chk("res_pulse_end", res_valid, 0);
        chk("mispred_cnt", mispred_cnt, m_cnt);
        chk("f_pred_new", f_pred, m_bht[idx] >> 1);
    endtask

    task automatic model_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
        logic t;
        t = ref_taken(f3, rs1, rs2);
        do_branch(f3, pc, imm, rs1, rs2, pred, t, t ? pc + imm : pc + 32'd4, f3[2:1] == 2'b01);
    endtask

    vec_t tbl[8];

    initial begin
        int acc, nres, rpos[$];
        tbl[0] = '{3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0, 1'b1, 32'h120, 1'b0};
        tbl[1] = '{3'b100, 32'h300, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'h310, 1'b0};
        tbl[2] = '{3'b110, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h204, 1'b0};
        tbl[3] = '{3'b001, 32'h80, 32'hFFFFFFF0, 32'h3, 32'h4, 1'b0, 1'b1, 32'h70, 1'b0};
        tbl[4] = '{3'b101, 32'h10, 32'h40, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 32'h14, 1'b0};
        tbl[5] = '{3'b111, 32'h24, 32'h8, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 32'h2C, 1'b0};
        tbl[6] = '{3'b010, 32'h44, 32'h8, 32'h7, 32'h7, 1'b1, 1'b0, 32'h48, 1'b1};
        tbl[7] = '{3'b011, 32'hFFFFFFFC, 32'h8, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 1'b1};

        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        chk("rst_br_ready", br_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_taken", res_taken, 0);
        chk("rst_res_target", res_target, 0);
        chk("rst_res_mispredict", res_mispredict, 0);
        chk("rst_res_illegal", res_illegal, 0);
        chk("rst_cmp_un", cmp_un, 0);
        chk("rst_cmp_rr1", cmp_rr1, 0);
        chk("rst_cmp_rr2", cmp_rr2, 0);
        chk("rst_cnt", mispred_cnt, 0);
        chk("rst_f_pred", f_pred, 0);

        // Directed vector table
        for (int i = 0; i < 8; i++)
            do_branch(tbl[i].f3, tbl[i].pc, tbl[i].imm, tbl[i].rs1, tbl[i].rs2, tbl[i].pred,
                      tbl[i].taken, tbl[i].tgt, tbl[i].ill);

        // BHT saturation at pc 0x40
        do_reset();
        for (int i = 0; i < 5; i++) model_branch(3'b000, 32'h40, 32'h100, 32'h9, 32'h9, 1'b1);
        f_pc = 32'h40; #1;
        chk("bht_sat_pred", f_pred, 1);
        model_branch(3'b000, 32'h40, 32'h100, 32'h9, 32'h8, 1'b1);
        chk("bht_10_pred", f_pred, 1);
        model_branch(3'b000, 32'h40, 32'h100, 32'h9, 32'h8, 1'b1);
        chk("bht_01_pred", f_pred, 0);

        // br_valid held for 9 cycles: one accept per 3 cycles
        do_reset();
        acc = 0; nres = 0;
        @(negedge clk);
        drive(3'b000, 32'h8, 32'h4, 32'h1, 32'h1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            if (br_valid && br_ready) acc++;
            if (res_valid) begin nres++; rpos.push_back(c); end
            @(negedge clk);
        end
        br_valid = 0;
        chk("hs_accepts", acc, 3);
        chk("hs_res_pulses", nres, 3);
        if (rpos.size() == 3) begin
            chk("hs_first_lat", rpos[0], 2);
            chk("hs_spacing1", rpos[1] - rpos[0], 3);
            chk("hs_spacing2", rpos[2] - rpos[1], 3);
        end
        chk("hs_tail_res", res_valid, 0);

        // kill while in CMP
        do_reset();
        f_pc = 32'h100;
        @(negedge clk);
        drive(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0);
        @(negedge clk);
        br_valid = 0; kill = 1;
        @(negedge clk);
        kill = 0; #1;
        chk("kcmp_res_valid", res_valid, 0);
        chk("kcmp_br_ready", br_ready, 1);
        @(negedge clk);
        chk("kcmp_res_later", res_valid, 0);
        chk("kcmp_cnt", mispred_cnt, 0);
        chk("kcmp_bht", f_pred, 0);

        // kill while in RES
        drive(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0);
        @(negedge clk);
        br_valid = 0;
        @(negedge clk);
        kill = 1; #1;
        chk("kres_res_valid", res_valid, 0);
        @(negedge clk);
        kill = 0; #1;
        chk("kres_br_ready", br_ready, 1);
        chk("kres_cnt", mispred_cnt, 0);
        chk("kres_bht", f_pred, 0);

        // kill with br_valid in IDLE blocks the accept
        @(negedge clk);
        kill = 1;
        drive(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0);
        #1;
        chk("kidle_ready", br_ready, 0);
        @(negedge clk);
        kill = 0; br_valid = 0; #1;
        chk("kidle_still_idle", br_ready, 1);
        @(negedge clk);
        chk("kidle_no_res", res_valid, 0);

        // Reset asserted during RES
        do_reset();
        model_branch(3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0);
        @(negedge clk);
        drive(3'b001, 32'h104, 32'h20, 32'h5, 32'h6, 1'b0);
        @(negedge clk);
        br_valid = 0;
        @(negedge clk);
        chk("rres_pre_valid", res_valid, 1);
        rst = 1;
        @(negedge clk);
        rst = 0; #1;
        chk("rres_res_valid", res_valid, 0);
        chk("rres_cnt", mispred_cnt, 0);
        chk("rres_ready", br_ready, 1);
        for (int i = 0; i < NENT; i++) begin
            f_pc = i << 2; #1;
            chk("rres_bht", f_pred, 0);
        end
        model_reset();
        @(negedge clk);
        chk("rres_no_residual", res_valid, 0);

        // Random branches against the model; counter reaches saturation
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7) - 4;
            b = ($urandom_range(0, 3) == 0) ? a : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 7) - 4);
            model_branch(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)) << 2, $urandom,
                         a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences the shared branch comparator (un/rr1/rr2 in, beq/blt out) for conditional branches in the pipelined core.
- Accepts one branch at a time from decode over a valid/ready handshake, drives the comparator, and resolves taken/not-taken from funct3.
- Computes the target, flags mispredicts against a 2-bit-counter branch history table (BHT), updates the BHT and counts mispredicts.
- Sits between decode/ID and the PC-select/flush logic.

Parameters:
- BHT_IDX, 4, BHT index width; the BHT has 2^BHT_IDX entries, indexed by pc[BHT_IDX+1:2].
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- kill  in  1  pipeline flush from an older instruction; cancels any in-flight branch.
- br_valid  in  1  decode presents a branch.
- br_ready  out  1  block can accept a branch.
- br_funct3  in  3  branch funct3.
- br_pc  in  32  branch PC.
- br_imm  in  32  sign-extended B-immediate.
- br_rs1  in  32  rs1 operand.
- br_rs2  in  32  rs2 operand.
- br_pred  in  1  prediction fetch used for this branch.
- f_pc  in  32  fetch PC for lookup.
- f_pred  out  1  combinational prediction: MSB of BHT[f_pc[BHT_IDX+1:2]].
- cmp_un  out  1  to comparator un.
- cmp_rr1  out  32  to comparator rr1.
- cmp_rr2  out  32  to comparator rr2.
- cmp_beq  in  1  from comparator.
- cmp_blt  in  1  from comparator.
- res_valid  out  1  one-cycle resolution pulse.
- res_taken  out  1  resolved direction.
- res_target  out  32  next PC for this branch.
- res_mispredict  out  1  res_taken != latched br_pred; qualified by res_valid.
- res_illegal  out  1  funct3 is 010 or 011; qualified by res_valid.
- mispred_cnt  out  CNT_W  saturating mispredict count.

Behaviour:
- FSM states: IDLE, CMP, RES. Reset state is IDLE.
- Reset values: res_* = 0, cmp_* = 0, mispred_cnt = 0, all BHT entries = 2'b01 (weakly not-taken). br_ready = 1 follows from IDLE && !kill.
- br_ready = (state == IDLE) && !kill. Accept happens when br_valid && br_ready.
- IDLE:
  - On accept, latch funct3, pc, imm, rs1, rs2, pred; go to CMP.
  - Otherwise stay in IDLE.
- CMP:
  - cmp_rr1/cmp_rr2 are registers loaded at accept. cmp_un = funct3[1], also registered at accept.
  - Sample cmp_beq/cmp_blt at the end of CMP. Taken decode:
    - 000: beq
    - 001: !beq
    - 100 and 110: blt
    - 101 and 111: !blt
    - 010 and 011: taken = 0, illegal = 1
  - Go to RES.
- RES:
  - res_valid = 1 for exactly this cycle.
  - res_target = taken ? pc + imm : pc + 4, both mod 2^32 (wrap-around ignored).
  - res_mispredict = taken ^ pred.
  - BHT[pc[BHT_IDX+1:2]] updates on this edge: +1 if taken, -1 if not taken, saturating at 00 and 11. An illegal branch does not update the BHT.
  - mispred_cnt increments on a legal mispredict and saturates at all-ones.
  - Next state: IDLE.
- Latency: accept at cycle N gives res_valid at N+2. Throughput is 1 branch per 3 cycles.
- kill:
  - In CMP or RES: next state IDLE. No res_valid is emitted in that cycle or later; no BHT or counter update.
  - In IDLE: blocks the accept.
  - Priority order: rst > kill > normal operation.
- f_pred read in the same cycle as a RES update to the same index returns the old (pre-update) value.
- Reset mid-operation: immediately IDLE and all reset values apply; no residual res_valid.
- cmp_* outputs hold their last value when idle.

Test Plan:
- BEQ taken: rs1 = rs2 = 0x5, funct3 = 000, pc = 0x100, imm = 0x20, pred = 0 → res_valid 2 cycles after accept; taken = 1, target = 0x120, mispredict = 1, mispred_cnt = 1, BHT[0] goes 01→10.
- Signed vs unsigned: rs1 = 0xFFFFFFFF, rs2 = 0x1. funct3 = 100 → taken = 1, cmp_un = 0. funct3 = 110 → taken = 0, cmp_un = 1. For the not-taken case with pc = 0x200: target = 0x204.
- BHT saturation: 4 taken branches at pc = 0x40 → entry 11, f_pred(0x40) = 1. A fifth taken branch keeps it at 11. A later not-taken branch → 10, f_pred still 1.
- Handshake: br_valid held high for 9 cycles → exactly 3 accepts (br_ready high only in IDLE), 3 res_valid pulses spaced 3 cycles apart.
- kill in CMP → no res_valid, BHT and mispred_cnt unchanged, br_ready = 1 the next cycle. kill together with br_valid in IDLE → not accepted.
- Illegal and reset cases: funct3 = 010 → res_illegal = 1, taken = 0, no BHT update. rst asserted in RES → res_valid = 0, all BHT entries = 01, mispred_cnt = 0.
